// File: rtl/led_spike_monitor.sv
// led_spike_monitor: per-neuron spike counting over fixed windows, winner pick and LED display
module led_spike_monitor #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int FAST_WIN_HZ = 1000,
  parameter int NUM_NEURONS = 8
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   Local_Reset,
  input  logic [31:0]            cfg,
  input  logic [NUM_NEURONS-1:0] spike_in,
  output logic [NUM_NEURONS-1:0] leds,
  output logic [3:0]             winner,
  output logic                   winner_valid,
  output logic                   window_tick,
  output logic                   gpio3
);
  localparam int WW = $clog2(CLK_FREQ_HZ + 1);
  localparam logic [WW-1:0] FAST_LAST = WW'(CLK_FREQ_HZ / FAST_WIN_HZ - 1);
  localparam logic [WW-1:0] SLOW_LAST = WW'(CLK_FREQ_HZ - 1);
  logic [WW-1:0] win_cnt;
  logic [7:0] pwm_cnt;
  logic slow_q, mode_chg, tick, val_nx;
  logic [7:0] cnt [NUM_NEURONS];
  logic [7:0] cnt_nx [NUM_NEURONS];
  logic [7:0] latched_cnt [NUM_NEURONS];
  logic [3:0] best_idx, win_nx;
  logic [7:0] best_val;
  logic [NUM_NEURONS-1:0] pwm_led, led_nx;
  logic unused_cfg;
  assign unused_cfg = ^{cfg[31:NUM_NEURONS+8], cfg[7:6], cfg[4], cfg[2]};
  // a window-length change restarts the window instead of ending it
  assign mode_chg = slow_q ^ cfg[3];
  assign tick = !mode_chg && win_cnt == (slow_q ? SLOW_LAST : FAST_LAST);
  assign window_tick = tick;
  // saturating next counts, winner search over them (strict > keeps lowest index on ties), PWM compare
  always_comb begin
    best_idx = '0;
    best_val = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      cnt_nx[i] = cnt[i] + {7'd0, spike_in[i] && cnt[i] != 8'hff};
      pwm_led[i] = latched_cnt[i] > pwm_cnt;
      if (cnt_nx[i] > best_val) begin
        best_idx = 4'(i);
        best_val = cnt_nx[i];
      end
    end
  end
  // next winner and LED selection; leds track the winner value being registered alongside
  always_comb begin
    win_nx = tick ? best_idx : winner;
    val_nx = tick ? best_val != 8'd0 : winner_valid;
    led_nx = cfg[1] ? cfg[NUM_NEURONS+7:8] : cfg[0] ? pwm_led :
             val_nx ? NUM_NEURONS'(1) << win_nx : '0;
  end
  // window timing, PWM ramp and registered outputs
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset)
    if (Local_Reset) begin
      slow_q <= 1'b0;
      win_cnt <= '0;
      pwm_cnt <= '0;
      winner <= '0;
      winner_valid <= 1'b0;
      leds <= '0;
      gpio3 <= 1'b0;
    end else begin
      slow_q <= cfg[3];
      win_cnt <= (mode_chg || tick) ? '0 : win_cnt + WW'(1);
      pwm_cnt <= pwm_cnt == 8'd254 ? 8'd0 : pwm_cnt + 8'd1;
      winner <= win_nx;
      winner_valid <= val_nx;
      leds <= led_nx;
      gpio3 <= cfg[5];
    end
  // spike counters restart every window; the tick-cycle spike lands only in the latched value
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset)
    if (Local_Reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cnt[i] <= '0;
        latched_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cnt[i] <= (mode_chg || tick) ? 8'd0 : cnt_nx[i];
        if (tick) latched_cnt[i] <= cnt_nx[i];
      end
    end
endmodule

// File: tb/tb_led_spike_monitor.sv
// tb_led_spike_monitor: scoreboard bench for window counting, winner, display modes and reset
module tb_led_spike_monitor;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] cfg = '0;
  logic [7:0] spike_in = '0;
  logic [7:0] leds;
  logic [3:0] winner;
  logic winner_valid, window_tick, gpio3;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [3:0] w; logic v; logic [7:0] l;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  led_spike_monitor #(.CLK_FREQ_HZ(1000), .FAST_WIN_HZ(100), .NUM_NEURONS(8)) dut (
    .S_AXI_ACLK(clk), .Local_Reset(rst), .cfg(cfg), .spike_in(spike_in), .leds(leds),
    .winner(winner), .winner_valid(winner_valid), .window_tick(window_tick), .gpio3(gpio3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic spikes(input logic [7:0] m, input int n);
    spike_in = m;
    repeat (n) cyc();
    spike_in = '0;
  endtask

  task automatic expect_win(input logic [3:0] w, input logic v, input logic [7:0] l);
    exp_t e;
    e.w = w;
    e.v = v;
    e.l = l;
    sb.push_back(e);
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!window_tick && n < budget);
    check("tick_seen", window_tick, 1);
  endtask

  task automatic sync();
    int n;
    wait_tick(30, n);
    cyc();
  endtask

  task automatic count_led0(input int exp);
    int c = 0;
    repeat (255) begin
      @(negedge clk);
      c += int'(leds[0]);
    end
    check("pwm_on_cycles", c, exp);
    cyc();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (window_tick) begin
        @(negedge clk);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("winner", winner, e.w);
          check("winner_valid", winner_valid, e.v);
          check("leds", leds, e.l);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    #12;
    check("rst_leds", leds, 0);
    check("rst_winner", winner, 0);
    check("rst_valid", winner_valid, 0);
    check("rst_gpio3", gpio3, 0);
    check("rst_tick", window_tick, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    sync();
    spikes(8'h24, 3);
    spikes(8'h20, 2);
    expect_win(4'd5, 1'b1, 8'h20);
    sync();
    spikes(8'h42, 4);
    expect_win(4'd1, 1'b1, 8'h02);
    sync();
    repeat (2) cyc();
    expect_win(4'd0, 1'b0, 8'h00);
    sync();
    spikes(8'h0a, 2);
    expect_win(4'd3, 1'b1, 8'h08);
    wait_tick(30, n);
    spike_in = 8'h08;
    cyc();
    spike_in = '0;
    repeat (2) cyc();
    expect_win(4'd0, 1'b0, 8'h00);
    sync();
    cyc();
    cfg = 32'h0000_A502;
    cyc();
    check("direct_leds", leds, 8'ha5);
    spikes(8'hff, 12);
    check("direct_leds_spikes", leds, 8'ha5);
    check("direct_gpio3", gpio3, 0);
    cfg = 32'h0000_0020;
    cyc();
    check("gpio3_set", gpio3, 1);
    cfg = 32'h1;
    spike_in = 8'h01;
    repeat (45) cyc();
    count_led0(10);
    cfg = 32'h9;
    wait_tick(1100, n);
    repeat (2) cyc();
    count_led0(255);
    spike_in = '0;
    cfg = 32'h0;
    repeat (3) cyc();
    sync();
    spikes(8'h04, 3);
    repeat (3) cyc();
    cfg = 32'h8;
    expect_win(4'd0, 1'b0, 8'h00);
    @(negedge clk);
    check("no_tick_on_toggle", window_tick, 0);
    wait_tick(1100, n);
    check("slow_tick_delay", n, 1000);
    cyc();
    cfg = 32'h20;
    repeat (3) cyc();
    sync();
    spikes(8'h10, 2);
    expect_win(4'd4, 1'b1, 8'h10);
    sync();
    spikes(8'h01, 3);
    repeat (2) cyc();
    check("pre_rst_leds", leds, 8'h10);
    check("pre_rst_gpio3", gpio3, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_leds", leds, 0);
    check("mid_rst_winner", winner, 0);
    check("mid_rst_valid", winner_valid, 0);
    check("mid_rst_gpio3", gpio3, 0);
    check("mid_rst_tick", window_tick, 0);
    cfg = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_win(4'd0, 1'b0, 8'h00);
    wait_tick(30, n);
    check("post_rst_tick_delay", n, 10);
    repeat (2) cyc();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
